max1119x_conv_scheduler: RTL and testbench

//  Sequences conversions of the MAX1119x ADC capture core and packs the results into an AXIS stream.
//  - Issues conversion requests from a periodic timer or a software trigger.
//  - Selects the channel (fixed or alternating CH0/CH1) for each request.
//  - Waits for each conversion with a timeout.
//  - Emits one 16-bit beat per sample, with TLAST closing each FRAME_LEN-sample frame.
//  - Sits between the processor-facing control registers and the ADC serial front end; the AXIS side feeds the DMA.

---
 rtl/max1119x_conv_scheduler.sv | 221 ++++++++++++++++++++++
 tb/tb_max1119x_conv_scheduler.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/max1119x_conv_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : max1119x_conv_scheduler
// Purpose  : Schedules MAX1119x conversions from a periodic timer or a
//            software trigger. Picks the channel for each request, waits for
//            completion with a timeout, and streams each result as one AXIS
//            beat. TLAST closes every FRAME_LEN-sample frame.
// Revision : 1.0 - initial release
// ============================================================================
module max1119x_conv_scheduler #(
    parameter int SAMPLE_PERIOD = 1000,
    parameter int FRAME_LEN     = 16,
    parameter int CONV_TIMEOUT  = 4096
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        enable,
    input  logic        sw_trigger,
    input  logic [1:0]  ch_mask,
    input  logic        clear_flags,
    output logic        conv_start,
    output logic        conv_ch,
    input  logic        conv_done,
    input  logic [15:0] conv_data,
    input  logic        m_axis_tready,
    output logic [15:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    output logic        m_axis_tlast,
    output logic [1:0]  m_axis_tkeep,
    output logic        busy,
    output logic        overrun,
    output logic        timeout
);

    localparam int c_TMR_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int c_FRM_W = (FRAME_LEN > 1)     ? $clog2(FRAME_LEN)     : 1;
    localparam int c_TMO_W = (CONV_TIMEOUT > 1)  ? $clog2(CONV_TIMEOUT)  : 1;

    localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(SAMPLE_PERIOD - 1);
    localparam logic [c_FRM_W-1:0] c_FRM_LAST = c_FRM_W'(FRAME_LEN - 1);
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(CONV_TIMEOUT - 1);

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_START = 2'd1;
    localparam logic [1:0] c_S_WAIT  = 2'd2;

    logic [1:0]         r_state;
    logic [c_TMR_W-1:0] r_timer;
    logic [c_FRM_W-1:0] r_frame;
    logic [c_TMO_W-1:0] r_tmo;
    logic               r_pending;
    logic               r_next_ch;
    logic               r_conv_start;
    logic               r_conv_ch;
    logic [15:0]        r_tdata;
    logic               r_tvalid;
    logic               r_tlast;
    logic [1:0]         r_tkeep;
    logic               r_overrun;
    logic               r_timeout;

    logic w_wrap;
    logic w_event;
    logic w_mask_any;
    logic w_idle;
    logic w_launch;
    logic w_launch_ch;
    logic w_trig_drop;
    logic w_capture;
    logic w_load;
    logic w_smp_drop;
    logic w_tmo_hit;

    // A timer wrap and a software trigger in the same cycle form one event.
    assign w_wrap      = enable && (r_timer == c_TMR_LAST);
    assign w_event     = w_wrap || (sw_trigger && enable);
    assign w_mask_any  = |ch_mask;
    assign w_idle      = (r_state == c_S_IDLE);
    assign w_launch    = w_idle && r_pending && w_mask_any;
    assign w_launch_ch = (ch_mask == 2'b10) ? 1'b1 :
                         (ch_mask == 2'b01) ? 1'b0 : r_next_ch;
    // An event is lost if one is already queued or a conversion is in flight.
    assign w_trig_drop = w_event && w_mask_any && (r_pending || !w_idle);
    assign w_capture   = (r_state == c_S_WAIT) && conv_done;
    // The single output slot accepts a sample if empty or draining this cycle.
    assign w_load      = w_capture && (!r_tvalid || m_axis_tready);
    assign w_smp_drop  = w_capture && !w_load;
    assign w_tmo_hit   = (r_state == c_S_WAIT) && !conv_done && (r_tmo == c_TMO_LAST);

    // Sample-period timer, held at zero while disabled.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_timer <= '0;
        end else if (!enable || w_wrap) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + c_TMR_W'(1);
        end
    end

    // Single-entry trigger queue; an empty channel mask discards events.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_pending <= 1'b0;
        end else if (!enable || !w_mask_any) begin
            r_pending <= 1'b0;
        end else if (w_event && !r_pending && w_idle) begin
            r_pending <= 1'b1;
        end else if (w_launch) begin
            r_pending <= 1'b0;
        end
    end

    // Alternation state for the dual-channel mask, restarting at CH0 on disable.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_next_ch <= 1'b0;
        end else if (!enable) begin
            r_next_ch <= 1'b0;
        end else if (w_launch && (ch_mask == 2'b11)) begin
            r_next_ch <= ~r_next_ch;
        end
    end

    // Conversion sequencer: IDLE -> START (one-cycle request) -> WAIT.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= c_S_IDLE;
            r_conv_start <= 1'b0;
            r_conv_ch    <= 1'b0;
            r_tmo        <= '0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (w_launch) begin
                        r_state      <= c_S_START;
                        r_conv_start <= 1'b1;
                        r_conv_ch    <= w_launch_ch;
                    end
                end
                c_S_START: begin
                    r_conv_start <= 1'b0;
                    r_tmo        <= '0;
                    r_state      <= c_S_WAIT;
                end
                c_S_WAIT: begin
                    if (conv_done || (r_tmo == c_TMO_LAST)) begin
                        r_state <= c_S_IDLE;
                    end else begin
                        r_tmo <= r_tmo + c_TMO_W'(1);
                    end
                end
                default: begin
                    r_state      <= c_S_IDLE;
                    r_conv_start <= 1'b0;
                end
            endcase
        end
    end

    // AXIS output slot: holds a beat until the handshake, reloads on capture.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_tdata  <= '0;
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
            r_tkeep  <= 2'b00;
        end else if (w_load) begin
            r_tdata  <= conv_data;
            r_tvalid <= 1'b1;
            r_tlast  <= (r_frame == c_FRM_LAST);
            r_tkeep  <= 2'b11;
        end else if (r_tvalid && m_axis_tready) begin
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
            r_tkeep  <= 2'b00;
        end
    end

    // Position of the next loaded beat within its frame.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_frame <= '0;
        end else if (!enable) begin
            r_frame <= '0;
        end else if (w_load) begin
            r_frame <= (r_frame == c_FRM_LAST) ? '0 : r_frame + c_FRM_W'(1);
        end
    end

    // Sticky status flags; a new set outranks a simultaneous clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_overrun <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            if (w_trig_drop || w_smp_drop) begin
                r_overrun <= 1'b1;
            end else if (clear_flags) begin
                r_overrun <= 1'b0;
            end
            if (w_tmo_hit) begin
                r_timeout <= 1'b1;
            end else if (clear_flags) begin
                r_timeout <= 1'b0;
            end
        end
    end

    assign conv_start    = r_conv_start;
    assign conv_ch       = r_conv_ch;
    assign m_axis_tdata  = r_tdata;
    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tlast  = r_tlast;
    assign m_axis_tkeep  = r_tkeep;
    assign busy          = !w_idle;
    assign overrun       = r_overrun;
    assign timeout       = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_max1119x_conv_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_max1119x_conv_scheduler
// Purpose  : Scoreboard bench for max1119x_conv_scheduler. The stimulus
//            queues the expected requests and the ADC model queues the
//            expected beats. Independent monitors pop and compare them when
//            the DUT issues conv_start or completes an AXIS handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_max1119x_conv_scheduler;

    typedef struct {
        logic [15:0] data;
        logic        last;
    } beat_t;

    typedef struct {
        logic ch;
        int   cyc;
    } start_t;

    logic        clk;
    logic        resetn;
    logic        enable;
    logic        sw_trigger;
    logic [1:0]  ch_mask;
    logic        clear_flags;
    logic        conv_start;
    logic        conv_ch;
    logic        conv_done;
    logic [15:0] conv_data;
    logic        m_axis_tready;
    logic [15:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic [1:0]  m_axis_tkeep;
    logic        busy;
    logic        overrun;
    logic        timeout;

    int     n_tests = 0;
    int     n_fail  = 0;
    int     cyc     = 0;
    int     base    = 0;
    int     epoch   = 0;
    bit     adc_respond = 1'b0;
    bit     push_en     = 1'b0;
    int     adc_delay   = 5;
    logic [15:0] adc_data = 16'h0000;

    beat_t  exp_beats[$];
    start_t exp_starts[$];

    max1119x_conv_scheduler #(
        .SAMPLE_PERIOD (10),
        .FRAME_LEN     (4),
        .CONV_TIMEOUT  (8)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .enable        (enable),
        .sw_trigger    (sw_trigger),
        .ch_mask       (ch_mask),
        .clear_flags   (clear_flags),
        .conv_start    (conv_start),
        .conv_ch       (conv_ch),
        .conv_done     (conv_done),
        .conv_data     (conv_data),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tkeep  (m_axis_tkeep),
        .busy          (busy),
        .overrun       (overrun),
        .timeout       (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running cycle index used to time-stamp conversion requests.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_clear();
        clear_flags = 1'b1;
        tick(1);
        clear_flags = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_conv_start"}, 32'(conv_start), 32'd0);
        check({tag, "_conv_ch"},    32'(conv_ch),    32'd0);
        check({tag, "_tvalid"},     32'(m_axis_tvalid), 32'd0);
        check({tag, "_tdata"},      32'(m_axis_tdata),  32'd0);
        check({tag, "_tlast"},      32'(m_axis_tlast),  32'd0);
        check({tag, "_tkeep"},      32'(m_axis_tkeep),  32'd0);
        check({tag, "_busy"},       32'(busy),    32'd0);
        check({tag, "_overrun"},    32'(overrun), 32'd0);
        check({tag, "_timeout"},    32'(timeout), 32'd0);
    endtask

    task automatic push_start(input logic ch, input int offs);
        start_t s;
        s.ch  = ch;
        s.cyc = base + offs;
        exp_starts.push_back(s);
    endtask

    // ADC front-end model: answers each request after adc_delay cycles and
    // queues the beat it expects, with TLAST every fourth queued beat.
    initial begin
        int fcnt = 0;
        int seen_epoch = 0;
        beat_t b;
        conv_done = 1'b0;
        conv_data = 16'h0000;
        forever begin
            @(negedge clk);
            if (conv_start && adc_respond) begin
                repeat (adc_delay) @(posedge clk);
                #1;
                if (adc_respond) begin
                    conv_done = 1'b1;
                    conv_data = adc_data;
                    if (push_en) begin
                        if (epoch != seen_epoch) begin
                            fcnt = 0;
                            seen_epoch = epoch;
                        end
                        b.data = adc_data;
                        b.last = (fcnt == 3);
                        exp_beats.push_back(b);
                        fcnt = (fcnt + 1) % 4;
                    end
                    adc_data = adc_data + 16'h0101;
                    @(posedge clk);
                    #1;
                    conv_done = 1'b0;
                end
            end
        end
    end

    // Beat monitor: compare every AXIS handshake against the queued beat.
    always @(negedge clk) begin
        if (resetn && m_axis_tvalid && m_axis_tready) begin
            if (exp_beats.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL beat_unexpected: got tdata 0x%0h, expected no beat", m_axis_tdata);
            end else begin
                beat_t e;
                e = exp_beats.pop_front();
                check("beat_tdata", 32'(m_axis_tdata), 32'(e.data));
                check("beat_tlast", 32'(m_axis_tlast), 32'(e.last));
                check("beat_tkeep", 32'(m_axis_tkeep), 32'd3);
            end
        end
    end

    // Request monitor: compare channel and cycle of every conv_start pulse.
    always @(negedge clk) begin
        if (resetn && conv_start) begin
            if (exp_starts.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL start_unexpected: got conv_start at cycle %0d, expected none", cyc);
            end else begin
                start_t e;
                e = exp_starts.pop_front();
                check("start_ch",  32'(conv_ch), 32'(e.ch));
                check("start_cyc", 32'(cyc),     32'(e.cyc));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of run by 100000, expected $finish");
        $fatal(1, "watchdog");
    end

    // Directed stimulus.
    initial begin
        resetn        = 1'b0;
        enable        = 1'b0;
        sw_trigger    = 1'b0;
        ch_mask       = 2'b00;
        clear_flags   = 1'b0;
        m_axis_tready = 1'b0;
        tick(3);
        check_all_zero("reset");
        resetn = 1'b1;
        tick(3);

        // 1: timer-driven CH0, one request every 10 cycles, TLAST on beats 4 and 8.
        ch_mask = 2'b01; m_axis_tready = 1'b1; adc_respond = 1'b1; push_en = 1'b1;
        adc_data = 16'hA000;
        enable = 1'b1; base = cyc;
        for (int k = 0; k < 8; k++) push_start(1'b0, 11 + 10 * k);
        tick(88);
        enable = 1'b0; epoch++;
        tick(4);
        check("t1_beats_left",  32'(exp_beats.size()),  32'd0);
        check("t1_starts_left", 32'(exp_starts.size()), 32'd0);

        // 2: alternating channels; disabling restarts channel and frame count.
        ch_mask = 2'b11; adc_data = 16'hB000;
        enable = 1'b1; base = cyc;
        push_start(1'b0, 11); push_start(1'b1, 21); push_start(1'b0, 31);
        tick(38);
        enable = 1'b0; epoch++;
        tick(3);
        enable = 1'b1; base = cyc;
        push_start(1'b0, 11); push_start(1'b1, 21); push_start(1'b0, 31); push_start(1'b1, 41);
        tick(48);
        enable = 1'b0; epoch++;
        tick(4);
        check("t2_beats_left",  32'(exp_beats.size()),  32'd0);
        check("t2_starts_left", 32'(exp_starts.size()), 32'd0);

        // 3: software trigger during WAIT is lost and flags overrun.
        ch_mask = 2'b01; adc_data = 16'hC000;
        enable = 1'b1; base = cyc;
        push_start(1'b0, 11);
        tick(12);
        check("t3_overrun_pre", 32'(overrun), 32'd0);
        tick(1);
        check("t3_busy_wait", 32'(busy), 32'd1);
        sw_trigger = 1'b1;
        tick(1);
        sw_trigger = 1'b0;
        check("t3_overrun_set", 32'(overrun), 32'd1);
        tick(4);
        enable = 1'b0; epoch++;
        tick(2);
        pulse_clear();
        check("t3_overrun_clr", 32'(overrun), 32'd0);
        check("t3_starts_left", 32'(exp_starts.size()), 32'd0);

        // 4: no conv_done, timeout after 8 WAIT cycles, no beat.
        adc_respond = 1'b0;
        enable = 1'b1; base = cyc;
        push_start(1'b0, 11);
        tick(12);
        enable = 1'b0; epoch++;
        tick(7);
        check("t4_busy_c19",    32'(busy),    32'd1);
        check("t4_timeout_c19", 32'(timeout), 32'd0);
        tick(1);
        check("t4_busy_c20",    32'(busy),    32'd0);
        check("t4_timeout_c20", 32'(timeout), 32'd1);
        check("t4_tvalid_c20",  32'(m_axis_tvalid), 32'd0);
        tick(3);
        check("t4_tvalid_c23",  32'(m_axis_tvalid), 32'd0);
        pulse_clear();
        check("t4_timeout_clr", 32'(timeout), 32'd0);

        // 5: stalled sink holds the first beat and drops the second.
        adc_respond = 1'b1; push_en = 1'b1; m_axis_tready = 1'b0; adc_data = 16'h1234;
        enable = 1'b1; base = cyc;
        push_start(1'b0, 11); push_start(1'b0, 21);
        tick(17);
        check("t5_tvalid_c17", 32'(m_axis_tvalid), 32'd1);
        check("t5_tdata_c17",  32'(m_axis_tdata),  32'h1234);
        check("t5_tkeep_c17",  32'(m_axis_tkeep),  32'd3);
        check("t5_tlast_c17",  32'(m_axis_tlast),  32'd0);
        tick(3);
        push_en = 1'b0;
        tick(7);
        check("t5_tdata_c27",  32'(m_axis_tdata),  32'h1234);
        check("t5_tvalid_c27", 32'(m_axis_tvalid), 32'd1);
        check("t5_overrun",    32'(overrun),       32'd1);
        tick(1);
        enable = 1'b0; epoch++;
        tick(2);
        m_axis_tready = 1'b1;
        tick(1);
        check("t5_tvalid_after", 32'(m_axis_tvalid), 32'd0);
        check("t5_tkeep_after",  32'(m_axis_tkeep),  32'd0);
        check("t5_beats_left",   32'(exp_beats.size()), 32'd0);
        pulse_clear();

        // 6: reset during WAIT with a held beat, then no request until a new event.
        ch_mask = 2'b10; push_en = 1'b0; adc_respond = 1'b1; m_axis_tready = 1'b0;
        adc_data = 16'hBEEF;
        enable = 1'b1; base = cyc;
        push_start(1'b1, 11); push_start(1'b1, 21);
        tick(23);
        check("t6_busy_pre",   32'(busy),          32'd1);
        check("t6_tvalid_pre", 32'(m_axis_tvalid), 32'd1);
        resetn = 1'b0; enable = 1'b0; adc_respond = 1'b0; epoch++;
        #1;
        check_all_zero("t6_async");
        tick(2);
        resetn = 1'b1;
        tick(30);
        check("t6_busy_idle",   32'(busy), 32'd0);
        check("t6_starts_left", 32'(exp_starts.size()), 32'd0);
        ch_mask = 2'b11; m_axis_tready = 1'b1; push_en = 1'b1; adc_respond = 1'b1;
        adc_data = 16'h5A5A;
        enable = 1'b1; sw_trigger = 1'b1; base = cyc;
        push_start(1'b0, 2);
        tick(1);
        sw_trigger = 1'b0;
        tick(7);
        enable = 1'b0; epoch++;
        tick(5);
        check("t6_beats_left",  32'(exp_beats.size()),  32'd0);
        check("t6_starts_left2", 32'(exp_starts.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
